rx_fifo: RTL

RX_FIFO -- requirements
Module: rx_fifo

---
 rtl/uart_pkg.sv | 38 +++
 rtl/fifo_mem.sv | 37 +++
 rtl/rx_fifo.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive-path types: FIFO entry layout, status bit positions, default depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // Default number of entries in the receive FIFO.
    localparam int RX_FIFO_DEPTH_DEFAULT = 16;

    // Default received character width.
    localparam int RX_DATA_WIDTH_DEFAULT = 8;

    // Status field layout as seen on rd_o_status: {parity_error, frame_error}.
    localparam int RX_STATUS_W          = 2;
    localparam int RX_STATUS_PARITY_BIT = 1;
    localparam int RX_STATUS_FRAME_BIT  = 0;

    typedef struct packed {
        logic parity_error;
        logic frame_error;
    } rx_status_t;

    // One stored character with its line-error flags; status sits above data.
    typedef struct packed {
        rx_status_t                           status;
        logic [RX_DATA_WIDTH_DEFAULT-1:0]     data;
    } rx_fifo_entry_t;

    // Pack the two error flags into the rd_o_status bit order.
    function automatic logic [RX_STATUS_W-1:0] rx_pack_status(input logic parity_error,
                                                              input logic frame_error);
        logic [RX_STATUS_W-1:0] s;
        s                       = '0;
        s[RX_STATUS_PARITY_BIT] = parity_error;
        s[RX_STATUS_FRAME_BIT]  = frame_error;
        return s;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: one write port, one registered read port, array not reset.
// Latency: read data valid one clock after rd_en; read-during-write to the same address returns old data.
// Backpressure: none; the caller guarantees legal addresses and enables.
module fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; contents survive reset so only pointers need clearing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; output register holds between reads and clears on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rx_fifo.sv
// UART receive FIFO: edge-detected writes from the deserializer, host reads, sticky overflow.
// Latency: read data/status/valid one clock after an accepted rd_i_en; write visible in count next clock.
// Backpressure: none upstream; writes while full (without a same-cycle read) are dropped and flag overflow.
// Build option: define RX_FIFO_STATUS_EN to store parity/frame error flags per entry.
module rx_fifo
    import uart_pkg::*;
#(
    // Must be a power of two in 4..256 so pointers wrap naturally.
    parameter int DEPTH      = RX_FIFO_DEPTH_DEFAULT,
    parameter int DATA_WIDTH = RX_DATA_WIDTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    wr_i_data,
    input  logic                     wr_i_valid,
    input  logic                     wr_i_parity_error,
    input  logic                     wr_i_frame_error,
    input  logic                     rd_i_en,
    output logic [DATA_WIDTH-1:0]    rd_o_data,
    output logic [1:0]               rd_o_status,
    output logic                     rd_o_valid,
    input  logic                     ovf_i_clr,
    output logic                     fifo_o_full,
    output logic                     fifo_o_empty,
    output logic                     fifo_o_overflow,
    output logic [$clog2(DEPTH):0]   fifo_o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef RX_FIFO_STATUS_EN
    localparam int EW = DATA_WIDTH + RX_STATUS_W;
`else
    localparam int EW = DATA_WIDTH;
`endif

    logic            valid_q;
    logic            wr_det;
    logic            wr_acc;
    logic            rd_acc;
    logic            ovf_set;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            overflow;
    logic            rd_vld_q;
    logic            full;
    logic            empty;
    logic [EW-1:0]   wr_entry;
    logic [EW-1:0]   rd_entry;

    // Flags come straight from the registered count.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A write is one rising edge of the deserializer's valid level.
    assign wr_det  = wr_i_valid & ~valid_q;
    assign rd_acc  = rd_i_en & ~empty;
    // When full, a same-cycle read frees the slot the write lands in.
    assign wr_acc  = wr_det & (~full | rd_acc);
    assign ovf_set = wr_det & full & ~rd_acc;

`ifdef RX_FIFO_STATUS_EN
    assign wr_entry    = {rx_pack_status(wr_i_parity_error, wr_i_frame_error), wr_i_data};
    assign rd_o_status = rd_entry[EW-1 -: RX_STATUS_W];
`else
    logic unused_status;
    assign unused_status = wr_i_parity_error ^ wr_i_frame_error;
    assign wr_entry      = wr_i_data;
    assign rd_o_status   = '0;
`endif

    assign rd_o_data       = rd_entry[DATA_WIDTH-1:0];
    assign rd_o_valid      = rd_vld_q;
    assign fifo_o_full     = full;
    assign fifo_o_empty    = empty;
    assign fifo_o_overflow = overflow;
    assign fifo_o_count    = count;

    // Next occupancy: simultaneous write and read cancel; never wraps since wr_acc/rd_acc respect full/empty.
    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Valid history resets high so a level already asserted at reset release is not taken as a new character.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b1;
        end else begin
            valid_q <= wr_i_valid;
        end
    end

    // Pointer and occupancy state; reset drops every entry in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
        end
    end

    // Sticky overflow; a new drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_i_clr) begin
            overflow <= 1'b0;
        end
    end

    // Read-valid pulse lines up with the memory's registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_acc;
        end
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

endmodule
